// File: rtl/fpu_req_tagger.sv
// Tag allocator and response terminator in front of the per-core FPU wrapper.
// Holds writeback metadata per outstanding tag and accumulates per-warp sticky fflags.
module fpu_req_tagger #(
  parameter int NUM_LANES  = 1,
  parameter int NUM_WARPS  = 4,
  parameter int TAG_SIZE   = 8,
  parameter int META_WIDTH = 16,
  parameter int XLEN       = 32,
  localparam int WIDW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int TAGW = (TAG_SIZE > 1) ? $clog2(TAG_SIZE) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [WIDW-1:0]           req_wid,
  input  logic [NUM_LANES-1:0]      req_mask,
  input  logic [META_WIDTH-1:0]     req_meta,
  output logic                      fpu_req_valid,
  input  logic                      fpu_req_ready,
  output logic [TAGW-1:0]           fpu_req_tag,
  input  logic                      fpu_rsp_valid,
  output logic                      fpu_rsp_ready,
  input  logic [TAGW-1:0]           fpu_rsp_tag,
  input  logic [NUM_LANES*XLEN-1:0] fpu_rsp_data,
  input  logic                      fpu_rsp_has_fflags,
  input  logic [4:0]                fpu_rsp_fflags,
  output logic                      commit_valid,
  input  logic                      commit_ready,
  output logic [WIDW-1:0]           commit_wid,
  output logic [NUM_LANES-1:0]      commit_mask,
  output logic [META_WIDTH-1:0]     commit_meta,
  output logic [NUM_LANES*XLEN-1:0] commit_data,
  input  logic                      fflags_clr_valid,
  input  logic [WIDW-1:0]           fflags_clr_wid,
  input  logic [WIDW-1:0]           fflags_rd_wid,
  output logic [4:0]                fflags_rd_data,
  output logic                      busy
);

  logic [TAG_SIZE-1:0]   free_q;
  logic [TAG_SIZE-1:0]   free_d;
  logic [WIDW-1:0]       tbl_wid  [TAG_SIZE];
  logic [NUM_LANES-1:0]  tbl_mask [TAG_SIZE];
  logic [META_WIDTH-1:0] tbl_meta [TAG_SIZE];
  logic [4:0]            fflags_acc   [NUM_WARPS];
  logic [4:0]            fflags_acc_d [NUM_WARPS];

  logic [TAGW-1:0]       alloc_tag;
  logic                  any_free;
  logic                  issue_fire;
  logic                  rsp_fire;
  logic                  commit_fire;
  logic                  fflags_upd;
  logic [WIDW-1:0]       rsp_wid;
  logic [NUM_LANES-1:0]  rsp_mask;
  logic [META_WIDTH-1:0] rsp_meta;

  // Lowest-index free tag wins.
  always_comb begin
    alloc_tag = '0;
    for (int i = TAG_SIZE - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_tag = TAGW'(i);
    end
  end

  assign any_free      = |free_q;
  assign fpu_req_valid = req_valid & any_free;
  assign req_ready     = fpu_req_ready & any_free;
  assign fpu_req_tag   = alloc_tag;
  assign issue_fire    = req_valid & req_ready;

  assign fpu_rsp_ready = ~commit_valid | commit_ready;
  assign rsp_fire      = fpu_rsp_valid & fpu_rsp_ready;
  assign commit_fire   = commit_valid & commit_ready;

  assign rsp_wid  = tbl_wid[fpu_rsp_tag];
  assign rsp_mask = tbl_mask[fpu_rsp_tag];
  assign rsp_meta = tbl_meta[fpu_rsp_tag];

  // A returning tag is always busy, so the set and clear below never collide.
  always_comb begin
    free_d = free_q;
    if (rsp_fire)   free_d[fpu_rsp_tag] = 1'b1;
    if (issue_fire) free_d[alloc_tag]   = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (issue_fire) begin
      tbl_wid[alloc_tag]  <= req_wid;
      tbl_mask[alloc_tag] <= req_mask;
      tbl_meta[alloc_tag] <= req_meta;
    end
  end

  assign fflags_upd = rsp_fire & fpu_rsp_has_fflags & (|rsp_mask);

  // Clear is applied before the merge so a same-cycle response survives it.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      fflags_acc_d[w] = fflags_acc[w];
      if (fflags_clr_valid && (fflags_clr_wid == WIDW'(w)))
        fflags_acc_d[w] = 5'd0;
      if (fflags_upd && (rsp_wid == WIDW'(w)))
        fflags_acc_d[w] = fflags_acc_d[w] | fpu_rsp_fflags;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      free_q       <= '1;
      commit_valid <= 1'b0;
      commit_wid   <= '0;
      commit_mask  <= '0;
      commit_meta  <= '0;
      commit_data  <= '0;
      for (int w = 0; w < NUM_WARPS; w++) fflags_acc[w] <= 5'd0;
    end else begin
      free_q <= free_d;
      for (int w = 0; w < NUM_WARPS; w++) fflags_acc[w] <= fflags_acc_d[w];
      if (rsp_fire) begin
        commit_valid <= 1'b1;
        commit_wid   <= rsp_wid;
        commit_mask  <= rsp_mask;
        commit_meta  <= rsp_meta;
        commit_data  <= fpu_rsp_data;
      end else if (commit_fire) begin
        commit_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    fflags_rd_data = 5'd0;
    if (int'(fflags_rd_wid) < NUM_WARPS) fflags_rd_data = fflags_acc[fflags_rd_wid];
  end

  assign busy = ~(&free_q) | commit_valid;

  rsp_tag_busy: assert property (@(posedge clk) disable iff (!reset_n)
                                 rsp_fire |-> !free_q[fpu_rsp_tag])
    else $error("fpu_req_tagger: response for free tag %0d", fpu_rsp_tag);

endmodule

// File: tb/tb_fpu_req_tagger.sv
// Scoreboard bench for fpu_req_tagger: directed scenarios followed by random traffic
// against a behavioural model of tag allocation, commit beats and sticky fflags.
module tb_fpu_req_tagger;
  localparam int NUM_LANES  = 1;
  localparam int NUM_WARPS  = 4;
  localparam int TAG_SIZE   = 8;
  localparam int META_WIDTH = 16;
  localparam int XLEN       = 32;
  localparam int WIDW       = 2;
  localparam int TAGW       = 3;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      req_valid;
  logic                      req_ready;
  logic [WIDW-1:0]           req_wid;
  logic [NUM_LANES-1:0]      req_mask;
  logic [META_WIDTH-1:0]     req_meta;
  logic                      fpu_req_valid;
  logic                      fpu_req_ready;
  logic [TAGW-1:0]           fpu_req_tag;
  logic                      fpu_rsp_valid;
  logic                      fpu_rsp_ready;
  logic [TAGW-1:0]           fpu_rsp_tag;
  logic [NUM_LANES*XLEN-1:0] fpu_rsp_data;
  logic                      fpu_rsp_has_fflags;
  logic [4:0]                fpu_rsp_fflags;
  logic                      commit_valid;
  logic                      commit_ready;
  logic [WIDW-1:0]           commit_wid;
  logic [NUM_LANES-1:0]      commit_mask;
  logic [META_WIDTH-1:0]     commit_meta;
  logic [NUM_LANES*XLEN-1:0] commit_data;
  logic                      fflags_clr_valid;
  logic [WIDW-1:0]           fflags_clr_wid;
  logic [WIDW-1:0]           fflags_rd_wid;
  logic [4:0]                fflags_rd_data;
  logic                      busy;

  fpu_req_tagger #(
    .NUM_LANES(NUM_LANES), .NUM_WARPS(NUM_WARPS), .TAG_SIZE(TAG_SIZE),
    .META_WIDTH(META_WIDTH), .XLEN(XLEN)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid),
    .req_mask(req_mask), .req_meta(req_meta),
    .fpu_req_valid(fpu_req_valid), .fpu_req_ready(fpu_req_ready), .fpu_req_tag(fpu_req_tag),
    .fpu_rsp_valid(fpu_rsp_valid), .fpu_rsp_ready(fpu_rsp_ready), .fpu_rsp_tag(fpu_rsp_tag),
    .fpu_rsp_data(fpu_rsp_data), .fpu_rsp_has_fflags(fpu_rsp_has_fflags),
    .fpu_rsp_fflags(fpu_rsp_fflags),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_wid(commit_wid),
    .commit_mask(commit_mask), .commit_meta(commit_meta), .commit_data(commit_data),
    .fflags_clr_valid(fflags_clr_valid), .fflags_clr_wid(fflags_clr_wid),
    .fflags_rd_wid(fflags_rd_wid), .fflags_rd_data(fflags_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: which tags are in flight, what each carries, pending commit, flags.
  bit                    m_known = 1'b0;
  bit                    m_inflight [TAG_SIZE];
  logic [WIDW-1:0]       m_wid  [TAG_SIZE];
  logic [NUM_LANES-1:0]  m_mask [TAG_SIZE];
  logic [META_WIDTH-1:0] m_meta [TAG_SIZE];
  bit                    m_cv;
  logic [4:0]            m_acc [NUM_WARPS];
  logic [63:0]           exp_q [$];
  int                    n_checks = 0;
  int                    n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_free();
    for (int t = 0; t < TAG_SIZE; t++) if (!m_inflight[t]) return t;
    return -1;
  endfunction

  function automatic int inflight_cnt();
    int n = 0;
    for (int t = 0; t < TAG_SIZE; t++) n += int'(m_inflight[t]);
    return n;
  endfunction

  task automatic idle();
    req_valid = 0; req_wid = '0; req_mask = 1'b1; req_meta = '0;
    fpu_req_ready = 1; fpu_rsp_valid = 0; fpu_rsp_tag = '0; fpu_rsp_data = '0;
    fpu_rsp_has_fflags = 0; fpu_rsp_fflags = '0; commit_ready = 1;
    fflags_clr_valid = 0; fflags_clr_wid = '0;
  endtask

  task automatic rsp(input int tag, input bit has, input logic [4:0] flags);
    fpu_rsp_valid = 1; fpu_rsp_tag = TAGW'(tag); fpu_rsp_data = $urandom;
    fpu_rsp_has_fflags = has; fpu_rsp_fflags = flags;
  endtask

  // Called right after inputs are driven at a falling edge; returns at the next falling edge.
  task automatic step();
    int a, t;
    bit iss, rf;
    #1;
    a = lowest_free();
    if (m_known) begin
      chk("req_ready", 64'(req_ready), 64'((a >= 0) && fpu_req_ready));
      chk("fpu_req_valid", 64'(fpu_req_valid), 64'((a >= 0) && req_valid));
      if (a >= 0) chk("fpu_req_tag", 64'(fpu_req_tag), 64'(a));
      chk("fpu_rsp_ready", 64'(fpu_rsp_ready), 64'(!m_cv || commit_ready));
      chk("commit_valid", 64'(commit_valid), 64'(m_cv));
      chk("busy", 64'(busy), 64'((inflight_cnt() > 0) || m_cv));
      chk("fflags_rd", 64'(fflags_rd_data), 64'(m_acc[fflags_rd_wid]));
    end
    iss = req_valid && fpu_req_ready && (a >= 0);
    rf  = fpu_rsp_valid && (!m_cv || commit_ready);
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < TAG_SIZE; i++) m_inflight[i] = 0;
      for (int w = 0; w < NUM_WARPS; w++) m_acc[w] = '0;
      m_cv = 0;
      exp_q.delete();
      m_known = 1;
    end else begin
      t = int'(fpu_rsp_tag);
      if (fflags_clr_valid) m_acc[fflags_clr_wid] = '0;
      if (rf) begin
        exp_q.push_back({13'b0, m_wid[t], m_mask[t], m_meta[t], fpu_rsp_data});
        if (fpu_rsp_has_fflags && m_mask[t] != 0) m_acc[m_wid[t]] = m_acc[m_wid[t]] | fpu_rsp_fflags;
        m_inflight[t] = 0;
      end
      if (iss) begin
        m_inflight[a] = 1; m_wid[a] = req_wid; m_mask[a] = req_mask; m_meta[a] = req_meta;
      end
      if (rf) m_cv = 1;
      else if (commit_ready) m_cv = 0;
    end
    @(negedge clk);
  endtask

  // Monitor: every accepted commit beat must match the oldest expected beat.
  initial begin
    logic [63:0] got, e;
    forever begin
      @(negedge clk);
      #4;
      if (commit_valid === 1'b1 && commit_ready === 1'b1) begin
        got = {13'b0, commit_wid, commit_mask, commit_meta, commit_data};
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL commit_unexpected: got %0h required no beat", got);
        end else begin
          e = exp_q.pop_front();
          chk("commit_beat", got, e);
        end
      end
    end
  end

  initial begin
    logic [31:0] d0;
    int pick;
    idle();
    reset_n = 0; fflags_rd_wid = '0;
    @(negedge clk);
    step();
    reset_n = 1;

    for (int w = 0; w < NUM_WARPS; w++) begin
      fflags_rd_wid = WIDW'(w);
      #1;
      chk("rst_fflags", 64'(fflags_rd_data), 64'(0));
      if (w == 0) begin
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
      end
      step();
    end

    // Fill all tags, then one more request that must be refused.
    for (int i = 0; i < 9; i++) begin
      req_valid = 1; req_wid = WIDW'(i % 4); req_mask = 1'b1; req_meta = 16'h00A0 + 16'(i);
      #1;
      if (i < 8) begin
        chk("fill_tag", 64'(fpu_req_tag), 64'(i));
        chk("fill_ready", 64'(req_ready), 64'(1));
      end else begin
        chk("full_ready", 64'(req_ready), 64'(0));
        chk("full_valid", 64'(fpu_req_valid), 64'(0));
        chk("full_busy", 64'(busy), 64'(1));
      end
      step();
    end
    req_valid = 0;

    // Out-of-order responses and reuse of the freed tags.
    rsp(5, 0, 5'd0);
    step();
    rsp(2, 0, 5'd0);
    #1;
    chk("c1_valid", 64'(commit_valid), 64'(1));
    chk("c1_meta", 64'(commit_meta), 64'(16'h00A5));
    step();
    fpu_rsp_valid = 0;
    #1;
    chk("c2_meta", 64'(commit_meta), 64'(16'h00A2));
    step();
    req_valid = 1; req_wid = '0; req_meta = 16'h00B2;
    #1;
    chk("realloc_first", 64'(fpu_req_tag), 64'(2));
    step();
    req_meta = 16'h00B5;
    #1;
    chk("realloc_second", 64'(fpu_req_tag), 64'(5));
    step();
    req_valid = 0;

    // Commit backpressure then streaming without a bubble.
    rsp(0, 0, 5'd0);
    d0 = fpu_rsp_data;
    step();
    commit_ready = 0;
    rsp(1, 0, 5'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_rsp_ready", 64'(fpu_rsp_ready), 64'(0));
      chk("stall_meta", 64'(commit_meta), 64'(16'h00A0));
      chk("stall_data", 64'(commit_data), 64'(d0));
      step();
    end
    commit_ready = 1;
    #1;
    chk("unstall_rsp_ready", 64'(fpu_rsp_ready), 64'(1));
    step();
    rsp(3, 0, 5'd0);
    #1;
    chk("stream_valid", 64'(commit_valid), 64'(1));
    chk("stream_meta", 64'(commit_meta), 64'(16'h00A1));
    step();
    fpu_rsp_valid = 0;
    #1;
    chk("stream_valid2", 64'(commit_valid), 64'(1));
    chk("stream_meta2", 64'(commit_meta), 64'(16'h00A3));
    step();
    step();

    // Drain the rest; flags present but not flagged as valid.
    for (int k = 0; k < 5; k++) begin
      rsp((k == 0) ? 2 : k + 3, 0, 5'h1F);
      step();
    end
    fpu_rsp_valid = 0;
    step();

    // Sticky fflags for warp 1.
    req_valid = 1; req_wid = 2'd1; req_mask = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_meta = META_WIDTH'($urandom);
      step();
    end
    req_valid = 0;
    fflags_rd_wid = 2'd1;
    rsp(0, 1, 5'b00001);
    step();
    rsp(1, 1, 5'b10000);
    step();
    fpu_rsp_valid = 0;
    #1;
    chk("ff_accum", 64'(fflags_rd_data), 64'(5'b10001));
    step();
    rsp(2, 1, 5'b00100);
    fflags_clr_valid = 1; fflags_clr_wid = 2'd1;
    step();
    fflags_clr_valid = 0; fpu_rsp_valid = 0;
    #1;
    chk("ff_clr_merge", 64'(fflags_rd_data), 64'(5'b00100));
    step();
    rsp(3, 0, 5'h1F);
    step();
    fpu_rsp_valid = 0;
    #1;
    chk("ff_no_flags", 64'(fflags_rd_data), 64'(5'b00100));
    step();
    req_valid = 1; req_wid = 2'd1; req_mask = 1'b0;
    step();
    req_valid = 0; req_mask = 1'b1;
    rsp(0, 1, 5'h1F);
    step();
    fpu_rsp_valid = 0;
    #1;
    chk("ff_mask_zero", 64'(fflags_rd_data), 64'(5'b00100));
    step();
    fflags_rd_wid = 2'd0;
    #1;
    chk("ff_other_warp", 64'(fflags_rd_data), 64'(0));
    step();

    // Same-cycle issue and response with only tag 3 busy.
    req_valid = 1; req_wid = 2'd2;
    for (int k = 0; k < 4; k++) begin
      req_meta = META_WIDTH'($urandom);
      step();
    end
    req_valid = 0;
    for (int k = 0; k < 3; k++) begin
      rsp(k, 0, 5'd0);
      step();
    end
    rsp(3, 0, 5'd0);
    req_valid = 1;
    #1;
    chk("same_cycle_tag", 64'(fpu_req_tag), 64'(0));
    step();
    fpu_rsp_valid = 0;
    for (int k = 1; k < 4; k++) begin
      #1;
      chk("after_free_tag", 64'(fpu_req_tag), 64'(k));
      step();
    end
    req_wid = 2'd1;
    step();
    step();
    req_valid = 0;

    // Reset with 5 tags in flight and a stalled commit.
    commit_ready = 0;
    rsp(0, 1, 5'b01000);
    step();
    fpu_rsp_valid = 0;
    #1;
    chk("pre_rst_cv", 64'(commit_valid), 64'(1));
    step();
    reset_n = 0;
    step();
    reset_n = 1; commit_ready = 1; req_valid = 1; fflags_rd_wid = 2'd0;
    #1;
    chk("rst_mid_cv", 64'(commit_valid), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_tag", 64'(fpu_req_tag), 64'(0));
    chk("rst_mid_ff0", 64'(fflags_rd_data), 64'(0));
    step();
    req_valid = 0;
    for (int w = 1; w < NUM_WARPS; w++) begin
      fflags_rd_wid = WIDW'(w);
      #1;
      chk("rst_mid_ff", 64'(fflags_rd_data), 64'(0));
      step();
    end

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      req_wid = WIDW'($urandom); req_mask = NUM_LANES'($urandom); req_meta = META_WIDTH'($urandom);
      fpu_req_ready = ($urandom_range(0, 99) < 80);
      commit_ready = ($urandom_range(0, 99) < 70);
      fflags_clr_valid = ($urandom_range(0, 99) < 5);
      fflags_clr_wid = WIDW'($urandom); fflags_rd_wid = WIDW'($urandom);
      fpu_rsp_has_fflags = 1'($urandom); fpu_rsp_fflags = 5'($urandom); fpu_rsp_data = $urandom;
      fpu_rsp_valid = 0;
      if (inflight_cnt() > 0 && $urandom_range(0, 99) < 55) begin
        pick = $urandom_range(0, inflight_cnt() - 1);
        for (int t = 0; t < TAG_SIZE; t++) begin
          if (m_inflight[t]) begin
            if (pick == 0) begin fpu_rsp_valid = 1; fpu_rsp_tag = TAGW'(t); end
            pick--;
          end
        end
      end
      step();
    end

    // Drain everything still outstanding.
    idle();
    for (int k = 0; k < 2 * TAG_SIZE + 4; k++) begin
      if (inflight_cnt() > 0) rsp(lowest_in_flight(), 0, 5'd0);
      else fpu_rsp_valid = 0;
      step();
    end
    fpu_rsp_valid = 0;
    step();
    step();
    chk("drain_queue", 64'(exp_q.size()), 64'(0));
    chk("drain_busy", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  function automatic int lowest_in_flight();
    for (int t = 0; t < TAG_SIZE; t++) if (m_inflight[t]) return t;
    return 0;
  endfunction

endmodule

// File: doc/fpu_req_tagger.md
Name: fpu_req_tagger

Overview:
- Sits directly upstream of the per-core FPU wrapper and also terminates its response stream.
- On issue, allocates a free FPU tag and stores the instruction's writeback metadata in a tag table. Forwards the request and tag to the FPU.
- On response, looks up the metadata by tag, frees the tag and presents a registered commit beat.
- Accumulates per-warp sticky fflags for the FCSR read path.

Parameters:
- NUM_LANES, 1, SIMD lanes per request.
- NUM_WARPS, 4, warps sharing the FPU; WIDW = max(1, clog2(NUM_WARPS)).
- TAG_SIZE, 8, outstanding FPU ops; TAGW = max(1, clog2(TAG_SIZE)).
- META_WIDTH, 16, opaque writeback metadata (rd, PC index, etc.).
- XLEN, 32, lane data width.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  issue request
- req_ready  out  1  issue accepted when high with req_valid
- req_wid  in  WIDW  issuing warp
- req_mask  in  NUM_LANES  active lanes
- req_meta  in  META_WIDTH  writeback metadata
- fpu_req_valid  out  1  request valid to FPU
- fpu_req_ready  in  1  FPU ready_in
- fpu_req_tag  out  TAGW  allocated tag (FPU tag_in)
- fpu_rsp_valid  in  1  FPU valid_out
- fpu_rsp_ready  out  1  FPU ready_out
- fpu_rsp_tag  in  TAGW  FPU tag_out
- fpu_rsp_data  in  NUM_LANES*XLEN  FPU result
- fpu_rsp_has_fflags  in  1  response carries flags
- fpu_rsp_fflags  in  5  NV,DZ,OF,UF,NX
- commit_valid  out  1  writeback beat valid
- commit_ready  in  1  writeback accepted
- commit_wid  out  WIDW
- commit_mask  out  NUM_LANES
- commit_meta  out  META_WIDTH
- commit_data  out  NUM_LANES*XLEN
- fflags_clr_valid  in  1  clear sticky flags of fflags_clr_wid
- fflags_clr_wid  in  WIDW
- fflags_rd_wid  in  WIDW  read select
- fflags_rd_data  out  5  sticky flags of fflags_rd_wid (combinational read)
- busy  out  1  any tag allocated or commit_valid

Behaviour:
- State: free vector (TAG_SIZE bits), tag table entries {wid, mask, meta} (not reset), commit output register, fflags_acc[NUM_WARPS][5].
- Reset (reset_n=0 at clk edge): free = all ones; commit_valid = 0; commit_* data = 0; fflags_acc = 0. Effect: req_ready = fpu_req_ready, busy = 0, fflags_rd_data = 0.
- Reset mid-operation: all in-flight tags are dropped and the pending commit is discarded. The FPU is reset by the same signal.
- Allocation:
  - alloc_tag = lowest-index set bit of the free vector.
  - any_free = |free.
  - fpu_req_valid = req_valid & any_free.
  - req_ready = fpu_req_ready & any_free.
  - fpu_req_tag = alloc_tag.
  - On issue fire: table[alloc_tag] <= {req_wid, req_mask, req_meta}; free[alloc_tag] <= 0.
- Full: with no free tag, req_ready = 0 and fpu_req_valid = 0, regardless of fpu_req_ready.
- Response:
  - fpu_rsp_ready = ~commit_valid | commit_ready (single output register, no bubble under streaming).
  - On rsp fire: commit_valid <= 1; commit_{wid,mask,meta} <= table[fpu_rsp_tag]; commit_data <= fpu_rsp_data; free[fpu_rsp_tag] <= 1.
  - Latency is one cycle from rsp fire to commit_valid.
  - On commit fire without rsp fire: commit_valid <= 0.
  - commit outputs are stable while commit_valid & ~commit_ready.
- Responses may return in any order. A response whose tag is currently free is a protocol error and triggers a simulation assertion.
- Simultaneous issue and response in one cycle:
  - Allocation uses the free vector from before the cycle.
  - A freed tag becomes allocatable the next cycle.
  - Set and clear never hit the same index.
- fflags:
  - On rsp fire with fpu_rsp_has_fflags=1, fflags_acc[table[tag].wid] |= fpu_rsp_fflags.
  - Flags are merged only if table mask is nonzero.
  - fflags_clr_valid sets fflags_acc[clr_wid] to 0.
  - If a clear and an update target the same warp in the same cycle, result = new response flags only (clear first, then OR).
  - Reads reflect register state: no bypass of same-cycle updates.
- busy = ~(&free) | commit_valid.

Test Plan:
- Reset, fpu_req_ready=1, 9 back-to-back requests -> tags 0..7 issued in order; 9th cycle req_ready=0, fpu_req_valid=0; busy=1.
- After fill, respond tag 5 (meta 0x00A5) then tag 2 (meta 0x00A2) -> commit_meta 0x00A5 then 0x00A2, each one cycle after rsp fire; next allocation returns tag 2, then tag 5.
- commit_ready=0 for 4 cycles with commit_valid=1 -> fpu_rsp_ready=0, commit outputs unchanged; commit_ready=1 with rsp_valid=1 same cycle -> back-to-back commits, no bubble.
- wid 1 responses with fflags 5'b00001 then 5'b10000 -> fflags_rd_data(wid 1)=5'b10001. Clear wid 1 in the same cycle as a response with 5'b00100 -> 5'b00100. Response with has_fflags=0 and flags 5'h1F -> no change.
- Same-cycle issue and response for tag 3 with only tag 3 busy and others free -> issue gets tag 0 (lowest free), tag 3 freed next cycle.
- reset_n low for one cycle with 5 tags in flight and commit_valid=1 -> next cycle commit_valid=0, busy=0, all fflags 0, first issue gets tag 0.
